// File: rtl/fft_pkg.sv
// Shared definitions for the in-place radix-2 DIF FFT sequencer.
//   - IDLE/RD/WAIT/WR/DONE state encoding used by fft_bf_ctrl
//   - default FFT size (log2)
//   - clog2 helper for sizing small counters
package fft_pkg;

    localparam int FFT_N_LOG2_DEF = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } fft_state_e;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator for an in-place radix-2 DIF FFT.
// Maps (stage, butterfly index k) to the two operand addresses and the
// twiddle ROM index:
//   span = N >> (stage+1), grp = k >> (L-1-stage), pos = k & (span-1)
//   addr_a = grp*2*span + pos, addr_b = addr_a + span, tw_addr = pos << stage
// Ports:
//   stage   in  N_LOG2    current stage (0..N_LOG2-1)
//   k       in  N_LOG2-1  butterfly index within the stage (0..N/2-1)
//   addr_a  out N_LOG2    upper operand address
//   addr_b  out N_LOG2    lower operand address
//   tw_addr out N_LOG2-1  twiddle ROM index
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2_DEF
) (
    input  logic [N_LOG2-1:0] stage,
    input  logic [N_LOG2-2:0] k,
    output logic [N_LOG2-1:0] addr_a,
    output logic [N_LOG2-1:0] addr_b,
    output logic [N_LOG2-2:0] tw_addr
);

    logic [N_LOG2-1:0] span_s;
    logic [N_LOG2-2:0] mask_s;
    logic [N_LOG2-2:0] pos_s;
    logic [N_LOG2-2:0] grp_s;
    logic [N_LOG2-1:0] base_s;
    int                grp_sh_s;

    // Address arithmetic; every power-of-two product is done as a shift so
    // each intermediate fits exactly in its own width.
    always_comb begin
        grp_sh_s = N_LOG2 - 1 - int'(stage);
        // span = 2**(L-1) >> stage, span-1 = all-ones(L-1) >> stage
        span_s   = {1'b1, {(N_LOG2-1){1'b0}}} >> stage;
        mask_s   = {(N_LOG2-1){1'b1}} >> stage;
        pos_s    = k & mask_s;
        grp_s    = k >> grp_sh_s;
        // grp*2*span: append one zero (x2), then shift by log2(span)
        base_s   = {grp_s, 1'b0} << grp_sh_s;
        addr_a   = base_s + {1'b0, pos_s};
        addr_b   = base_s + {1'b0, pos_s} + span_s;
        tw_addr  = pos_s << stage;
    end

endmodule

// File: rtl/fft_bf_ctrl.sv
// Sequencer for an in-place radix-2 DIF FFT on one true dual-port BRAM with a
// single butterfly datapath. Each butterfly is RD -> WAIT(READ_LAT) -> WR on
// the same address pair; all log2(N) stages of N/2 butterflies are walked in
// order, then done pulses for one cycle.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   start    in   one-cycle run request, sampled only in IDLE
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse after the last write
//   mem_own  out  controller owns the BRAM ports (same as busy)
//   mem_en   out  BRAM enable, both ports (RD and WR)
//   mem_we   out  BRAM write enable, both ports (WR)
//   addr_a   out  port A address, upper operand x[i]
//   addr_b   out  port B address, lower operand x[i+span]
//   bf_en    out  read data valid; datapath captures butterfly result
//   tw_addr  out  twiddle ROM index, meaningful while bf_en=1
//   stage    out  current stage
// Every output is a flop loaded from the next-state values, so outputs line
// up with the state register and there is no combinational path from start.
module fft_bf_ctrl
    import fft_pkg::*;
#(
    parameter int N_LOG2   = FFT_N_LOG2_DEF,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_own,
    output logic              mem_en,
    output logic              mem_we,
    output logic [N_LOG2-1:0] addr_a,
    output logic [N_LOG2-1:0] addr_b,
    output logic              bf_en,
    output logic [N_LOG2-2:0] tw_addr,
    output logic [N_LOG2-1:0] stage
);

    localparam int                WCW    = (clog2(READ_LAT) < 1) ? 1 : clog2(READ_LAT);
    localparam logic [N_LOG2-2:0] K_LAST = {(N_LOG2-1){1'b1}};
    localparam logic [N_LOG2-1:0] S_LAST = N_LOG2'(N_LOG2 - 1);
    localparam logic [WCW-1:0]    W_INIT = WCW'(READ_LAT - 1);

    fft_state_e        state_r;
    fft_state_e        state_s;
    logic [N_LOG2-2:0] k_r;
    logic [N_LOG2-2:0] k_s;
    logic [N_LOG2-1:0] stage_s;
    logic [WCW-1:0]    wcnt_r;
    logic [WCW-1:0]    wcnt_s;

    logic              busy_s;
    logic              done_s;
    logic              mem_en_s;
    logic              mem_we_s;
    logic              bf_en_s;
    logic [N_LOG2-1:0] addr_a_s;
    logic [N_LOG2-1:0] addr_b_s;
    logic [N_LOG2-2:0] tw_addr_s;

    // Addresses are generated from the next (stage, k) so they are registered
    // together with the state that uses them.
    fft_addr_gen #(
        .N_LOG2 (N_LOG2)
    ) u_addr_gen (
        .stage   (stage_s),
        .k       (k_s),
        .addr_a  (addr_a_s),
        .addr_b  (addr_b_s),
        .tw_addr (tw_addr_s)
    );

    // Next-state, counter and next-output logic.
    always_comb begin
        state_s = state_r;
        stage_s = stage;
        k_s     = k_r;
        wcnt_s  = wcnt_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RD;
                    stage_s = {N_LOG2{1'b0}};
                    k_s     = {(N_LOG2-1){1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                state_s = WAIT;
                wcnt_s  = W_INIT;
            end
            WAIT: begin
                if (wcnt_r == {WCW{1'b0}}) begin
                    state_s = WR;
                end else begin
                    wcnt_s = wcnt_r - WCW'(1);
                end
            end
            WR: begin
                if (k_r != K_LAST) begin
                    k_s     = k_r + (N_LOG2-1)'(1);
                    state_s = RD;
                end else if (stage != S_LAST) begin
                    stage_s = stage + N_LOG2'(1);
                    k_s     = {(N_LOG2-1){1'b0}};
                    state_s = RD;
                end else begin
                    state_s = DONE;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s   = (state_s != IDLE);
        done_s   = (state_s == DONE);
        mem_en_s = (state_s == RD) || (state_s == WR);
        mem_we_s = (state_s == WR);
        // bf_en only on the final WAIT cycle, when read data is valid
        bf_en_s  = (state_s == WAIT) && (wcnt_s == {WCW{1'b0}});
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            k_r     <= {(N_LOG2-1){1'b0}};
            wcnt_r  <= {WCW{1'b0}};
            stage   <= {N_LOG2{1'b0}};
            busy    <= 1'b0;
            mem_own <= 1'b0;
            done    <= 1'b0;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            bf_en   <= 1'b0;
            addr_a  <= {N_LOG2{1'b0}};
            addr_b  <= {N_LOG2{1'b0}};
            tw_addr <= {(N_LOG2-1){1'b0}};
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            wcnt_r  <= wcnt_s;
            stage   <= stage_s;
            busy    <= busy_s;
            mem_own <= busy_s;
            done    <= done_s;
            mem_en  <= mem_en_s;
            mem_we  <= mem_we_s;
            bf_en   <= bf_en_s;
            addr_a  <= addr_a_s;
            addr_b  <= addr_b_s;
            tw_addr <= tw_addr_s;
        end
    end

endmodule

// File: tb/tb_fft_bf_ctrl.sv
// Self-checking bench for fft_bf_ctrl. Two instances run side by side:
// inst0 N_LOG2=3/READ_LAT=1, inst1 N_LOG2=4/READ_LAT=2. The reference model
// expands each accepted start into the textbook DIF loop nest (stage, group,
// offset) as a queue of expected butterflies, and predicts control timing
// from the start cycle alone. A negedge monitor compares each cycle.
module tb_fft_bf_ctrl;

    localparam int L0 = 3;
    localparam int R0 = 1;
    localparam int L1 = 4;
    localparam int R1 = 2;
    localparam int LN [2] = '{L0, L1};
    localparam int PP [2] = '{R0 + 2, R1 + 2};

    typedef struct {
        int a;
        int b;
        int tw;
        int st;
    } bfly_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] start_s = 2'b00;
    int cyc = 0;

    logic busy0, own0, done0, en0, we0, bf0;
    logic [L0-1:0] aa0, ab0, st0;
    logic [L0-2:0] tw0;
    logic busy1, own1, done1, en1, we1, bf1;
    logic [L1-1:0] aa1, ab1, st1;
    logic [L1-2:0] tw1;

    bfly_t sbq [2][$];
    int run_c0 [2] = '{-1, -1};
    int done_c [2] = '{-1, -1};
    int n_chk = 0;
    int n_fail = 0;

    fft_bf_ctrl #(.N_LOG2(L0), .READ_LAT(R0)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]),
        .busy(busy0), .done(done0), .mem_own(own0), .mem_en(en0), .mem_we(we0),
        .addr_a(aa0), .addr_b(ab0), .bf_en(bf0), .tw_addr(tw0), .stage(st0)
    );

    fft_bf_ctrl #(.N_LOG2(L1), .READ_LAT(R1)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]),
        .busy(busy1), .done(done1), .mem_own(own1), .mem_en(en1), .mem_we(we1),
        .addr_a(aa1), .addr_b(ab1), .bf_en(bf1), .tw_addr(tw1), .stage(st1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expand one run into its expected butterfly sequence and timing.
    task automatic accept(input int i);
        int n;
        int span;
        bfly_t e;
        n = 1 << LN[i];
        run_c0[i] = cyc;
        done_c[i] = cyc + LN[i] * (n / 2) * PP[i] + 1;
        for (int s = 0; s < LN[i]; s++) begin
            span = n >> (s + 1);
            for (int base = 0; base < n; base += 2 * span) begin
                for (int j = 0; j < span; j++) begin
                    e.a = base + j;
                    e.b = base + j + span;
                    e.tw = j << s;
                    e.st = s;
                    sbq[i].push_back(e);
                end
            end
        end
    endtask

    task automatic drive(input int i, input logic v);
        start_s[i] = v;
        if (v && !rst && cyc > done_c[i]) accept(i);
    endtask

    task automatic step(input logic s0, input logic s1);
        @(negedge clk);
        #1;
        drive(0, s0);
        drive(1, s1);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            sbq[i].delete();
            run_c0[i] = -1;
            done_c[i] = -1;
        end
    endtask

    task automatic chk_zero(input string name);
        check({name, "_i0"}, {busy0, own0, done0, en0, we0, bf0, aa0, ab0, tw0, st0}, 32'd0);
        check({name, "_i1"}, {busy1, own1, done1, en1, we1, bf1, aa1, ab1, tw1, st1}, 32'd0);
    endtask

    task automatic mon(input int i, input logic busy, input logic own, input logic done,
                       input logic en, input logic we, input logic bf,
                       input int aa, input int ab, input int tw, input int st);
        logic act;
        logic [5:0] ev;
        int rel;
        int ph;
        bfly_t e;
        act = (run_c0[i] >= 0) && (cyc > run_c0[i]) && (cyc <= done_c[i]);
        ev = {act, act, 4'b0000};
        if (act && cyc < done_c[i]) begin
            rel = cyc - run_c0[i] - 1;
            ph = rel % PP[i];
            ev[2] = (ph == 0) || (ph == PP[i] - 1);
            ev[1] = (ph == PP[i] - 1);
            ev[0] = (ph == PP[i] - 2);
        end
        if (act && cyc == done_c[i]) ev[3] = 1'b1;
        check($sformatf("ctrl%0d{busy,own,done,en,we,bf}", i), {26'd0, busy, own, done, en, we, bf}, {26'd0, ev});
        if (en || bf) begin
            if (sbq[i].size() == 0) begin
                check($sformatf("sb_empty%0d", i), 32'd1, 32'd0);
            end else begin
                e = sbq[i][0];
                if (en) begin
                    check($sformatf("addr_a%0d", i), aa, e.a);
                    check($sformatf("addr_b%0d", i), ab, e.b);
                    check($sformatf("stage%0d", i), st, e.st);
                end
                if (bf) check($sformatf("tw_addr%0d", i), tw, e.tw);
                if (we) void'(sbq[i].pop_front());
            end
        end
    endtask

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        mon(0, busy0, own0, done0, en0, we0, bf0, int'(aa0), int'(ab0), int'(tw0), int'(st0));
        mon(1, busy1, own1, done1, en1, we1, bf1, int'(aa1), int'(ab1), int'(tw1), int'(st1));
    end

    initial begin
        logic s0;
        logic s1;
        int t;

        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset_state");
        rst = 1'b0;

        // Both instances start together; a second pulse mid-run is ignored.
        step(1'b1, 1'b1);
        repeat (9) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        // Hold start across inst0's DONE: the rerun starts on return to IDLE.
        while (cyc < done_c[0] - 3) step(1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0);
        check("rerun_after_done", run_c0[0] == done_c[0] - 37 ? 32'd1 : 32'd0, 32'd1);

        // Reset during the WR of the first stage-1 butterfly of inst0.
        t = run_c0[0] + 1 + 4 * PP[0] + PP[0] - 1;
        while (cyc < t - 1) step(1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("in_wr_before_rst", {30'd0, we0, st0 == 3'd1}, 32'd3);
        rst = 1'b1;
        start_s = 2'b00;
        clear_model();
        #1;
        chk_zero("async_rst");
        repeat (2) step(1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Restart from stage 0, k=0.
        step(1'b1, 1'b0);
        while (cyc <= done_c[0] || cyc <= done_c[1]) step(1'b0, 1'b0);

        // Random start traffic, including ignored pulses while busy.
        for (int n = 0; n < 3000; n++) begin
            s0 = (cyc > done_c[0]) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
            s1 = (cyc > done_c[1]) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
            step(s0, s1);
        end
        while (cyc <= done_c[0] || cyc <= done_c[1]) step(1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        check("sb_leftover0", sbq[0].size(), 32'd0);
        check("sb_leftover1", sbq[1].size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_bf_ctrl.md
Name: fft_bf_ctrl

Overview:
Sequencer for in-place radix-2 DIF FFT on one true dual-port BRAM with a single butterfly datapath. Each butterfly runs a read-then-write cycle: read both operands on ports A/B, strobe the butterfly/twiddle register stage, then write both results back to the same addresses.
Steps through all log2(N) stages of N/2 butterflies, generating addresses, twiddle index, enables and completion status. Sits between the host start/done handshake and the BRAM/BF datapath.

Parameters:
N_LOG2, 4, log2 of FFT size N (N = 2**N_LOG2, 2..10 supported)
READ_LAT, 1, BRAM read latency in cycles (1 or 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after last write
mem_own  out  1  controller owns BRAM ports (equals busy); datapath mux select
mem_en  out  1  BRAM enable, both ports
mem_we  out  1  BRAM write enable, both ports
addr_a  out  N_LOG2  port A address (upper operand, x[i])
addr_b  out  N_LOG2  port B address (lower operand, x[i+span])
bf_en  out  1  read data valid; datapath registers butterfly/twiddle result
tw_addr  out  N_LOG2-1  twiddle ROM index, valid while bf_en=1
stage  out  N_LOG2 bits wide enough for 0..N_LOG2-1  current stage

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, mem_own, mem_en, mem_we, bf_en = 0; addr_a, addr_b, tw_addr, stage = 0. No write is issued after reset, even mid-butterfly.
- States: IDLE, RD, WAIT, WR, DONE.
- IDLE: start=1 -> RD with stage=0, k=0. start in any other state is ignored.
- RD (1 cycle): mem_en=1, mem_we=0, addresses driven; go to WAIT with wait counter=READ_LAT-1.
- WAIT (READ_LAT cycles): addresses held; mem_en=0. bf_en=1 only on the last WAIT cycle (counter==0); then go to WR.
- WR (1 cycle): mem_en=1, mem_we=1, same addresses as RD.
- WR exit:
  - if k<N/2-1: k++, next state RD;
  - else if stage<N_LOG2-1: stage++, k=0, next state RD;
  - else DONE.
- DONE (1 cycle): done=1; next state IDLE.
- Address rule, L=N_LOG2, s=stage, k=butterfly index 0..N/2-1:
  - span = N>>(s+1)
  - grp = k>>(L-1-s)
  - pos = k & (span-1)
  - addr_a = grp*2*span + pos
  - addr_b = addr_a + span
  - tw_addr = pos<<s
  - All outputs are registered from state/counters; no combinational path from start.
- Timing: butterfly period = READ_LAT+2 cycles. start seen at cycle 0 -> first RD at cycle 1.
  - Last WR at cycle N_LOG2*(N/2)*(READ_LAT+2).
  - done at that cycle +1; busy is 0 the cycle after done.
- Output order is bit-reversed (DIF); reordering belongs to the unload path, not this block.
- Because each butterfly completes its write before the next read, there are no read-after-write hazards across stage boundaries and no inter-stage drain.
- Butterfly scaling (1/2 per stage) is a datapath concern; the controller is width-agnostic.

Decomposition:
- Shared package fft_pkg: state enum (IDLE/RD/WAIT/WR/DONE), default N_LOG2, function clog2 for stage width.
- Sub-module fft_addr_gen: purely combinational (stage, k) -> (addr_a, addr_b, tw_addr). Reused by verification as the reference model.
- Controller FSM and counters stay in fft_bf_ctrl.

Test Plan:
1. Reset with N_LOG2=3, READ_LAT=1; pulse start at cycle 0.
   - Stage0 pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
   - Stage1 pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2.
   - Stage2 pairs (0,1),(2,3),(4,5),(6,7), tw 0.
2. Same config: last WR at cycle 36, done=1 only at cycle 37, busy=1 cycles 1..37. Each butterfly shows RD(en=1,we=0), WAIT(bf_en=1), WR(en=1,we=1).
3. READ_LAT=2, N_LOG2=3: WAIT lasts 2 cycles with bf_en only on the second; done at cycle 49.
4. Pulse start again at cycle 10 of a run: no effect on sequence or done timing. start held high across DONE -> new run begins the cycle after returning to IDLE.
5. Assert rst during a WR of stage 1: all outputs 0 immediately, state IDLE, no further mem_we. A later start restarts from stage 0, k=0.
6. Full N_LOG2=4 run with scoreboard BRAM + BF model on input x[n]=n: bit-reversed results match golden FFT/16, within 1 LSB per stage.
